// File: rtl/c_port_arbiter_pkg.sv
// rtl/c_port_arbiter_pkg.sv - shared types and widths for the C-port arbiter
package usertype;

    localparam int C_ADDR_W = 8;
    localparam int C_DATA_W = 64;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} Arb_State;

endpackage

// File: rtl/arb_rr_pick2.sv
// rtl/arb_rr_pick2.sv - combinational 2-way picker, round-robin or fixed priority (ARB_FIXED_PRIO_EN)
module arb_rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt_onehot,
    output logic       gnt_idx
);

`ifdef ARB_FIXED_PRIO_EN
    // Requester 0 always wins; ptr is ignored.
    assign gnt_idx = ~req[0];
`else
    // On contention the pointer decides; otherwise the lone requester wins.
    assign gnt_idx = (&req) ? ptr : req[1];
`endif

    assign gnt_onehot = (|req) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/c_port_arbiter.sv
// rtl/c_port_arbiter.sv - two-requester arbiter/sequencer for the single C_* DRAM bridge port
// Grant policy selected in arb_rr_pick2 by ARB_FIXED_PRIO_EN (default: round-robin).
module c_port_arbiter
    import usertype::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_r_wb,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ack,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   C_addr,
    output logic [DATA_W-1:0]   C_data_w,
    output logic                C_in_valid,
    output logic                C_r_wb,
    input  logic                C_out_valid,
    input  logic [DATA_W-1:0]   C_data_r
);

    Arb_State   state;
    Arb_State   next_state;
    logic       owner;
    logic       rr_ptr;
    logic       issue;
    logic       complete;
    logic [1:0] gnt_onehot;
    logic       gnt_idx;

    arb_rr_pick2 u_pick (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A bridge completion outside ISSUE/WAIT is ignored by construction.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        complete   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|req_valid) begin
                    issue      = 1'b1;
                    next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (C_out_valid) begin
                    complete   = 1'b1;
                    next_state = ARB_IDLE;
                end else begin
                    next_state = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (C_out_valid) begin
                    complete   = 1'b1;
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            req_ack    <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            busy       <= 1'b0;
            C_addr     <= '0;
            C_data_w   <= '0;
            C_in_valid <= 1'b0;
            C_r_wb     <= 1'b0;
        end else begin
            C_in_valid <= issue;
            req_ack    <= issue ? gnt_onehot : 2'b00;
            rsp_valid  <= 2'b00;
            if (issue) begin
                owner    <= gnt_idx;
                busy     <= 1'b1;
                C_r_wb   <= gnt_idx ? req_r_wb[1] : req_r_wb[0];
                C_addr   <= gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                C_data_w <= gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            end
            if (complete) begin
                busy      <= 1'b0;
                rr_ptr    <= ~owner;
                rsp_valid <= owner ? 2'b10 : 2'b01;
                rsp_rdata <= C_r_wb ? C_data_r : '0;
            end
        end
    end

endmodule

// File: tb/tb_c_port_arbiter.sv
// tb/tb_c_port_arbiter.sv - scoreboard bench for c_port_arbiter with a latency-programmable bridge model
module tb_c_port_arbiter;
    import usertype::*;

    localparam int AW = 8;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:0]      req_valid;
    logic [1:0]      req_r_wb;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ack;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic [AW-1:0]   C_addr;
    logic [DW-1:0]   C_data_w;
    logic            C_in_valid;
    logic            C_r_wb;
    logic            C_out_valid;
    logic [DW-1:0]   C_data_r;

    c_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_r_wb    (req_r_wb),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .busy        (busy),
        .C_addr      (C_addr),
        .C_data_w    (C_data_w),
        .C_in_valid  (C_in_valid),
        .C_r_wb      (C_r_wb),
        .C_out_valid (C_out_valid),
        .C_data_r    (C_data_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          idx;
        logic          r_wb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic          idx;
        logic [DW-1:0] rdata;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];

    int   n_tests = 0;
    int   n_fail = 0;
    int   ack_count = 0;
    int   cyc = 0;
    int   last_out_cyc = -1;
    int   outstanding = 0;
    int   bridge_lat = 3;
    int   spur_cnt = 0;
    logic m_ptr = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bdata(input logic [AW-1:0] a);
        return 64'hDEAD_BEEF_0000_0000 | {{(DW-AW){1'b0}}, a};
    endfunction

    function automatic logic pick(input logic [1:0] r, input logic p);
`ifdef ARB_FIXED_PRIO_EN
        return r[0] ? 1'b0 : 1'b1;
`else
        return (r == 2'b11) ? p : r[1];
`endif
    endfunction

    // Bridge: answers each command after bridge_lat cycles; loses it if reset hits.
    initial begin
        int   spur_done;
        int   w;
        logic dead;
        spur_done   = 0;
        C_out_valid = 1'b0;
        C_data_r    = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && C_in_valid) begin
                w    = bridge_lat;
                dead = 1'b0;
                repeat (w) begin
                    @(posedge clk); #1;
                    if (!rst_n) dead = 1'b1;
                end
                if (!dead && rst_n) begin
                    C_out_valid = 1'b1;
                    C_data_r    = bdata(C_addr);
                    @(posedge clk); #1;
                    C_out_valid = 1'b0;
                    C_data_r    = '0;
                end
            end else if (spur_cnt != spur_done) begin
                spur_done   = spur_cnt;
                C_out_valid = 1'b1;
                C_data_r    = 64'h1;
                @(posedge clk); #1;
                C_out_valid = 1'b0;
                C_data_r    = '0;
            end
        end
    end

    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        cyc++;
        if (!rst_n) begin
            outstanding  = 0;
            last_out_cyc = -1;
        end else begin
            if (C_in_valid) begin
                check("issue_overlap", outstanding, 0);
                outstanding = 1;
                ack_count++;
                check("busy_in_issue", busy, 1);
                if (last_out_cyc >= 0) check("b2b_gap", (cyc - last_out_cyc) >= 2, 1);
                if (exp_cmd.size() == 0) begin
                    check("unexpected_issue", C_in_valid, 0);
                end else begin
                    c = exp_cmd.pop_front();
                    check("ack_idx", req_ack, c.idx ? 2'b10 : 2'b01);
                    check("c_addr", C_addr, c.addr);
                    check("c_r_wb", C_r_wb, c.r_wb);
                    check("c_data_w", C_data_w, c.wdata);
                end
            end else if (req_ack != 2'b00) begin
                check("ack_without_issue", req_ack, 0);
            end
            if (rsp_valid != 2'b00) begin
                outstanding = 0;
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 0);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_valid", rsp_valid, r.idx ? 2'b10 : 2'b01);
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("rsp_timing", cyc, last_out_cyc + 1);
                    check("busy_after_rsp", busy, 0);
                end
            end
            if (C_out_valid) last_out_cyc = cyc;
        end
    end

    task automatic set_req(input int k, input logic r_wb, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_r_wb[k]            = r_wb;
        req_addr[k*AW +: AW]   = a;
        req_wdata[k*DW +: DW]  = d;
    endtask

    task automatic push_txn(input logic k, input logic with_rsp);
        cmd_t c;
        rsp_t r;
        c.idx   = k;
        c.r_wb  = req_r_wb[k];
        c.addr  = req_addr[k*AW +: AW];
        c.wdata = req_wdata[k*DW +: DW];
        exp_cmd.push_back(c);
        if (with_rsp) begin
            r.idx   = k;
            r.rdata = c.r_wb ? bdata(c.addr) : '0;
            exp_rsp.push_back(r);
            m_ptr = ~k;
        end
    endtask

    task automatic wait_acks(input int tgt);
        int b;
        b = 0;
        while (ack_count < tgt && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (ack_count < tgt) check("timeout_ack", ack_count, tgt);
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while (exp_rsp.size() != 0 && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (exp_rsp.size() != 0) begin
            check("timeout_rsp", exp_rsp.size(), 0);
            exp_rsp.delete();
            exp_cmd.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [1:0] r, input int n);
        int tgt;
        for (int i = 0; i < n; i++) push_txn(pick(r, m_ptr), 1'b1);
        tgt = ack_count + n;
        req_valid = r;
        wait_acks(tgt);
        req_valid = 2'b00;
        wait_drain();
    endtask

    initial begin
        req_valid = '0;
        req_r_wb  = '0;
        req_addr  = '0;
        req_wdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {req_ack, rsp_valid, busy, C_in_valid, C_r_wb}, 0);
        check("rst_c_addr", C_addr, 0);
        check("rst_c_data_w", C_data_w, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        bridge_lat = 3;
        set_req(0, 1'b1, 8'h12, '0);
        run_txn(2'b01, 1);

        set_req(1, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        run_txn(2'b10, 1);

        bridge_lat = 2;
        set_req(0, 1'b1, 8'h10, '0);
        set_req(1, 1'b0, 8'h20, 64'h5555_AAAA_5555_AAAA);
        run_txn(2'b11, 4);

        bridge_lat = 0;
        run_txn(2'b11, 2);

        bridge_lat = 1;
        set_req(0, 1'b1, 8'h33, '0);
        run_txn(2'b01, 1);
        spur_cnt++;
        repeat (4) @(posedge clk);
        #1;
        set_req(0, 1'b1, 8'h34, '0);
        set_req(1, 1'b1, 8'h35, '0);
        run_txn(2'b11, 2);

        bridge_lat = 20;
        set_req(0, 1'b1, 8'h44, '0);
        run_txn(2'b01, 1);
        set_req(1, 1'b1, 8'h55, '0);
        push_txn(1'b1, 1'b0);
        req_valid = 2'b10;
        wait_acks(ack_count + 1);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_c_addr", C_addr, 0);
        check("async_rst_c_r_wb", C_r_wb, 0);
        check("async_rst_strobes", {req_ack, rsp_valid, C_in_valid}, 0);
        m_ptr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        bridge_lat = 2;
        set_req(0, 1'b1, 8'h66, '0);
        set_req(1, 1'b1, 8'h77, '0);
        run_txn(2'b11, 1);

        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("rsp_queue_empty", exp_rsp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
